// File: rtl/spi_pkg.sv
// spi_pkg: frame constants and FSM states shared by the spi2adc and spi2dac serial links
package spi_pkg;
  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;
  localparam int FRAME_BITS = 16;
  localparam int FIRST_DATA_BIT = 6;
  localparam int LAST_DATA_BIT = 15;
  localparam logic START = 1'b1;
  localparam logic SGL = 1'b1;
  localparam logic MSBF = 1'b1;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period counter producing a mode-0 SCK plus single-cycle rise/fall strikes
module spi_sck_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  logic [7:0] cnt;
  logic tc;
  assign tc = en && cnt == LAST;
  assign rise = tc && !sck;
  assign fall = tc && sck;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      sck <= ~sck;
    end else
      cnt <= cnt + 8'd1;
endmodule

// File: rtl/spi2adc.sv
// spi2adc: SPI master reading one 10-bit sample from an MCP3002-style ADC per start pulse
module spi2adc #(
  parameter int CLK_DIV = 25,
  parameter int CS_HOLD = 25
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       channel,
  input  logic       adc_sdo,
  output logic       adc_cs,
  output logic       adc_sck,
  output logic       adc_sdi,
  output logic [9:0] data_from_adc,
  output logic       data_valid,
  output logic       busy
);
  import spi_pkg::*;
  // HOLD exits one cycle early so the IDLE cycle completes the CS_HOLD gap and a held start repeats exactly
  localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD < 2 ? 0 : CS_HOLD - 2);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] DATA_LO = 4'(FIRST_DATA_BIT - 1);
  localparam logic [3:0] DATA_HI = 4'(LAST_DATA_BIT - 1);
  state_t state;
  logic [15:0] tx, hold_cnt;
  logic [9:0] rx;
  logic [3:0] bit_cnt;
  logic rise, fall;
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .en(state == XFER),
    .sck(adc_sck),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      adc_cs <= 1'b1;
      adc_sdi <= 1'b0;
      data_from_adc <= '0;
      data_valid <= 1'b0;
      busy <= 1'b0;
      tx <= '0;
      rx <= '0;
      bit_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= XFER;
          busy <= 1'b1;
          adc_cs <= 1'b0;
          adc_sdi <= START;
          tx <= {SGL, channel, MSBF, 13'b0};
          bit_cnt <= '0;
        end
        XFER: begin
          // bit_cnt counts completed falls, so it equals SCK period minus one at each rise
          if (rise && bit_cnt >= DATA_LO && bit_cnt <= DATA_HI)
            rx <= {rx[8:0], adc_sdo};
          if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            tx <= {tx[14:0], 1'b0};
            adc_sdi <= tx[15];
            if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
              adc_cs <= 1'b1;
              adc_sdi <= 1'b0;
              data_from_adc <= rx;
              data_valid <= 1'b1;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: if (hold_cnt == HOLD_LAST) begin
          state <= IDLE;
          busy <= 1'b0;
        end else
          hold_cnt <= hold_cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule
